// File: rtl/rr_reg_arbiter_if.sv
// Handshake bundle between N producers, the round-robin arbiter and one consumer.
// Latency: none (wires only); the arbiter registers out_* one cycle after a grant.
// Backpressure: out_ready low stalls the shared register; the arbiter then drops every gnt.
//
// Ports (slave = arbiter side):
//   req[N], in_data[N*W], out_ready   -> into the arbiter
//   gnt[N], out_valid, out_data[W], out_src[SW] <- out of the arbiter
interface rr_reg_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   gnt;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  // arbiter side
  modport slave (
    input  req, in_data, out_ready,
    output gnt, out_valid, out_data, out_src
  );

  // producer/consumer side
  modport master (
    output req, in_data, out_ready,
    input  gnt, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one pipeline register between N requesters.
// Latency: a word granted at edge k appears on out_data after edge k (1 cycle); 1 word/cycle sustained.
// Backpressure: out_valid=1 with out_ready=0 forces gnt=0 and holds out_data/out_src stable.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears register, source and priority pointer, blocks grants
//   bus  rr_reg_arbiter_if.slave: req/in_data/gnt towards producers,
//        out_valid/out_data/out_src/out_ready towards the consumer
module rr_reg_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  rr_reg_arbiter_if.slave bus
);
  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr;
  logic [SW-1:0] sel;
  logic [SW-1:0] ptr_nxt;
  logic          load;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_src_q;
  logic [SW:0]   cand;
  logic          found;

  // Unpack the flat input bus into per-requester words for the data mux.
  logic [W-1:0] words [N];
  for (genvar g = 0; g < N; g++) begin : g_words
    assign words[g] = bus.in_data[g*W +: W];
  end

  // Priority search: ptr first, then ptr+1 ... wrapping through N-1 to 0.
  // cand is one bit wider than ptr so the wrap compare works for any N.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (SW+1)'(k);
      if (cand >= (SW+1)'(N)) begin
        cand = cand - (SW+1)'(N);
      end
      if (!found && bus.req[cand[SW-1:0]]) begin
        found = 1'b1;
        sel   = cand[SW-1:0];
      end
    end
  end

  // Register can take a word when empty or draining this same cycle.
  assign load    = (|bus.req) & (~out_valid_q | bus.out_ready) & ~rst;
  assign ptr_nxt = (sel == SW'(N-1)) ? '0 : sel + 1'b1;

  assign bus.gnt       = load ? (N'(1) << sel) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr         <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= words[sel];
      out_src_q   <= sel;
      ptr         <= ptr_nxt;
    end else if (out_valid_q && bus.out_ready) begin
      // Drain with nothing to reload: data/source keep their last values.
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_reg_arbiter.sv
module tb_rr_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_reg_arbiter_if #(.N(N), .W(W)) bus ();

  rr_reg_arbiter #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Register contents and the rotating priority pointer as plain integers.
  int m_valid = 0;
  int m_data  = 0;
  int m_src   = 0;
  int m_ptr   = 0;

  // Winner: walk the requesters in priority order starting at p; -1 if none asks.
  function automatic int pick(input logic [N-1:0] r, input int p);
    int order[$];
    for (int k = 0; k < N; k++) order.push_back((p + k) % N);
    foreach (order[i]) if (r[order[i]]) return order[i];
    return -1;
  endfunction

  function automatic int may_load();
    if (rst === 1'b1) return 0;
    if (bus.req == '0) return 0;
    if (m_valid != 0 && bus.out_ready !== 1'b1) return 0;
    return 1;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    int w;
    if (may_load() == 0) return '0;
    w = pick(bus.req, m_ptr);
    return N'(1) << w;
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst === 1'b1) begin
      m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
    end else if (may_load() != 0) begin
      w       = pick(bus.req, m_ptr);
      m_valid = 1;
      m_data  = int'(bus.in_data[w*W +: W]);
      m_src   = w;
      m_ptr   = (w + 1) % N;
    end else if (m_valid != 0 && bus.out_ready === 1'b1) begin
      m_valid = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_gnt",       32'(bus.gnt),       32'(exp_gnt()));
    check("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("model_out_data",  32'(bus.out_data),  32'(m_data));
    check("model_out_src",   32'(bus.out_src),   32'(m_src));
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    bus.in_data[i*W +: W] = v;
  endtask

  initial begin
    logic [W-1:0] rot_data [5];
    int           rot_src  [5];
    rot_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    rot_src  = '{0, 1, 2, 3, 0};

    rst           = 1'b1;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset with all requesters asking
    tick();
    check("rst_gnt",       32'(bus.gnt),       32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_out_src",   32'(bus.out_src),   32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("first_gnt", 32'(bus.gnt), 32'b0001);

    // Rotation: all four held, sink always ready
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rot_valid", 32'(bus.out_valid), 32'h1);
      check("rot_src",   32'(bus.out_src),   32'(rot_src[i]));
      check("rot_data",  32'(bus.out_data),  32'(rot_data[i]));
    end
    // ptr is now 1

    // Backpressure: capture 0x55 from requester 2, then stall
    bus.req     = 4'b0100;
    bus.in_data = {8'h00, 8'h55, 8'h00, 8'h10};
    tick();
    check("bp_cap_data", 32'(bus.out_data), 32'h55);
    bus.out_ready = 1'b0;
    bus.req       = 4'b0011;
    repeat (3) begin
      #1;
      check("bp_gnt",  32'(bus.gnt),      32'h0);
      check("bp_data", 32'(bus.out_data), 32'h55);
      check("bp_src",  32'(bus.out_src),  32'h2);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_gnt", 32'(bus.gnt), 32'b0001);
    tick();
    check("bp_reload_data", 32'(bus.out_data), 32'h10);
    check("bp_reload_src",  32'(bus.out_src),  32'h0);

    // Wrap and skip: grant 2 (ptr -> 3), then only 2 asks again
    bus.req = 4'b0100;
    set_word(2, 8'h66);
    tick();
    set_word(2, 8'h67);
    #1;
    check("wrap_gnt", 32'(bus.gnt), 32'b0100);
    tick();
    check("wrap_data", 32'(bus.out_data), 32'h67);

    // Drain without reload; ptr must stay at 3
    bus.req = 4'b0000;
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'h0);
    check("drain_data",  32'(bus.out_data),  32'h67);
    check("drain_src",   32'(bus.out_src),   32'h2);
    bus.req = 4'b1010;
    set_word(3, 8'h33);
    set_word(1, 8'h77);
    #1;
    check("drain_ptr_gnt", 32'(bus.gnt), 32'b1000);
    tick();
    check("after_drain_data", 32'(bus.out_data), 32'h33);
    #1;
    check("skip_gnt", 32'(bus.gnt), 32'b0010);
    tick();
    check("pre_rst_data", 32'(bus.out_data), 32'h77);
    // ptr is now 2

    // Reset mid-operation with a live handshake offered
    rst     = 1'b1;
    bus.req = 4'b1000;
    #1;
    check("midrst_gnt", 32'(bus.gnt), 32'h0);
    tick();
    check("midrst_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_data",  32'(bus.out_data),  32'h0);
    check("midrst_src",   32'(bus.out_src),   32'h0);
    rst     = 1'b0;
    bus.req = 4'b1111;
    #1;
    check("midrst_ptr_gnt", 32'(bus.gnt), 32'b0001);
    tick();
    check("post_rst_data", 32'(bus.out_data), 32'h10);

    bus.req = 4'b0000;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
- Round-robin arbiter that shares one pipeline register (the single-flop sample stage, b -> a on posedge clk) between N requesters.
- Each requester offers a W-bit word with a valid/ready handshake (req/gnt).
- The winning word is captured into the shared register and presented downstream with out_valid/out_ready.
- Sits between several producers and one registered consumer stage; fairness is guaranteed by a rotating priority pointer.

Parameters:
- N, 4, number of requesters (≥2).
- W, 8, data width per requester.
- SW, $clog2(N), width of the source index (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high; one clock; reset is synchronous and active-high.
- req  input  N  req[i]=1: requester i offers in_data slice i.
- in_data  input  N*W  requester i word at bits [i*W +: W].
- gnt  output  N  one-hot combinational accept; req[i]&gnt[i] = transfer this cycle.
- out_valid  output  1  shared register holds an unconsumed word.
- out_data  output  W  shared register contents.
- out_src  output  SW  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts out_data when out_valid=1.

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_data=0, out_src=0, ptr=0.
  - gnt is forced to 0 while rst=1.
  - rst overrides any load or handshake in the same cycle; an in-flight word is discarded.
- State: the register is EMPTY (out_valid=0) or FULL (out_valid=1). No other FSM state beyond ptr (SW bits).
- load = (|req) & (~out_valid | out_ready) & ~rst.
- Arbitration: search starts at index ptr and wraps through ptr+1 … N-1, 0 … ptr-1. The first i with req[i]=1 wins (sel).
- gnt = load ? onehot(sel) : 0.
  - Purely combinational from req, out_valid, out_ready and ptr. No combinational path from in_data.
- On a posedge with load=1:
  - out_data ← in_data[sel*W +: W]
  - out_src ← sel
  - out_valid ← 1
  - ptr ← (sel+1) mod N, wrapping from N-1 to 0
- On a posedge with out_valid & out_ready & ~load: out_valid ← 0. out_data and out_src hold their last values.
- Otherwise all state holds.
- Latency: a word accepted at edge k is visible on out_data after edge k (1 cycle).
- Throughput: 1 word/cycle when out_ready stays 1. Drain and reload happen in the same cycle (back-to-back).
- Backpressure: with out_valid=1 and out_ready=0, gnt=0 for all requesters and out_data/out_src stay stable.
- Fairness: a requester that holds req continuously waits at most N-1 transfers.
- ptr advances only on load; it never moves while idle or stalled.
- Single requester: the same requester is granted every eligible cycle.
- Simultaneous req from all N: grants rotate ptr, ptr+1, …
- A requester may drop req without a grant; no penalty, no state change.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req=4'b1111 → gnt=0, out_valid=0, out_data=0, out_src=0. First cycle after release: gnt=4'b0001.
- Rotation: N=4, req=4'b1111 held, out_ready=1, words 0xA0..0xA3 → out_src sequence 0,1,2,3,0 on consecutive cycles, out_data matches, one-hot gnt every cycle.
- Backpressure: capture 0x55 from req[2], then out_ready=0 for 3 cycles with req=4'b0011 → gnt=0, out_data=0x55, out_src=2 held. out_ready=1 → same cycle gnt=4'b0001 (ptr=3 wraps to 0), next out_data=in_data[0].
- Wrap and skip: ptr=3 after granting index 2, req=4'b0100 only → gnt=4'b0100 (search 3,0,1,2), ptr←3.
- Drain without reload: out_valid=1, out_ready=1, req=0 → out_valid=0 next cycle, out_data held, ptr unchanged.
- Reset mid-operation: out_valid=1 (0x77), rst=1 with out_ready=1 and req=4'b1000 → next cycle out_valid=0, out_data=0, ptr=0, no transfer counted, gnt=0 during rst.
